// File: rtl/uart_rx_frame_parser.sv
// uart_rx_frame_parser: reads raw bytes from the UART rx FIFO and recognises frames
// laid out as SYNC, LEN, PAYLOAD[LEN], CHK. The payload is held in an internal buffer
// and is only released on the valid/ready stream after the XOR checksum matches.
module uart_rx_frame_parser #(
   parameter int unsigned CLK_FREQ   = 0,      // clock rate in Hz; always override with the real rate
   parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
   parameter int unsigned MAX_LEN    = 16,
   parameter int unsigned TIMEOUT_US = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       fifo_empty_i,
   input  logic [7:0] fifo_rd_data_i,
   output logic       fifo_rd_en_o,
   output logic [7:0] data_o,
   output logic       valid_o,
   output logic       last_o,
   input  logic       ready_i,
   output logic       frame_ok_o,
   output logic       frame_err_o,
   output logic [1:0] err_code_o
);

   localparam int unsigned IW        = $clog2(MAX_LEN + 1);
   localparam int unsigned AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int unsigned TO_RAW    = (CLK_FREQ / 1_000_000) * TIMEOUT_US;
   // A clock slower than 1 MHz would give a zero count, so clamp to one cycle.
   localparam int unsigned TO_CYCLES = (TO_RAW == 0) ? 1 : TO_RAW;
   localparam int unsigned TW        = $clog2(TO_CYCLES + 1);
   localparam logic [IW-1:0] ONE     = IW'(1);

   typedef enum logic [2:0] {SYNC, LEN, PAYLOAD, CHK, EMIT} state_t;

   state_t        state, state_n;
   logic          rd_pending;
   logic [7:0]    acc;
   logic [IW-1:0] len_q;
   logic [IW-1:0] idx;
   logic [IW-1:0] oidx;
   logic [IW-1:0] idx_inc;
   logic [IW-1:0] oidx_inc;
   logic [TW-1:0] tcnt;
   logic          tmr_run;
   logic          timeout;
   logic          ok_n;
   logic          err_n;
   logic [1:0]    code_n;
   logic [7:0]    buffer [MAX_LEN];

   assign idx_inc  = idx + ONE;
   assign oidx_inc = oidx + ONE;

   // Payload stream: only EMIT presents data, and data is forced to zero otherwise so
   // that the never-reset buffer contents cannot leak out while idle or in reset.
   assign valid_o = (state == EMIT);
   assign last_o  = valid_o && (oidx_inc == len_q);
   assign data_o  = valid_o ? buffer[oidx[AW-1:0]] : 8'h00;

   // One read at a time: the byte arrives the cycle after the strobe, so a new strobe
   // waits until the previous byte has been sampled. Held low during reset.
   assign fifo_rd_en_o = !rst && !fifo_empty_i && !rd_pending && (state != EMIT);

   // The inter-byte timer only matters while a frame is partially received. A byte
   // being sampled this cycle takes priority over an expiring count.
   assign tmr_run = (state == LEN) || (state == PAYLOAD) || (state == CHK);
   assign timeout = tmr_run && !rd_pending && (tcnt == TW'(TO_CYCLES - 1));

   // State register, outstanding-read flag and registered status pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= SYNC;
         rd_pending  <= 1'b0;
         frame_ok_o  <= 1'b0;
         frame_err_o <= 1'b0;
         err_code_o  <= 2'd0;
      end else begin
         state       <= state_n;
         rd_pending  <= fifo_rd_en_o;
         frame_ok_o  <= ok_n;
         frame_err_o <= err_n;
         err_code_o  <= code_n;
      end
   end

   // Next-state and pulse decisions: one step per sampled byte, plus timeout and EMIT exit.
   always_comb begin
      state_n = state;
      ok_n    = 1'b0;
      err_n   = 1'b0;
      code_n  = err_code_o;
      if (timeout) begin
         state_n = SYNC;
         err_n   = 1'b1;
         code_n  = 2'd3;
      end else if (rd_pending) begin
         case (state)
            SYNC: begin
               if (fifo_rd_data_i == SYNC_BYTE) state_n = LEN;
            end
            LEN: begin
               if (fifo_rd_data_i > 8'(MAX_LEN)) begin
                  state_n = SYNC;
                  err_n   = 1'b1;
                  code_n  = 2'd1;
               end else if (fifo_rd_data_i == 8'h00) begin
                  state_n = CHK;
               end else begin
                  state_n = PAYLOAD;
               end
            end
            PAYLOAD: begin
               if (idx_inc == len_q) state_n = CHK;
            end
            CHK: begin
               if (fifo_rd_data_i == acc) begin
                  ok_n    = 1'b1;
                  state_n = (len_q == '0) ? SYNC : EMIT;
               end else begin
                  state_n = SYNC;
                  err_n   = 1'b1;
                  code_n  = 2'd2;
               end
            end
            default: ;
         endcase
      end else if ((state == EMIT) && ready_i && last_o) begin
         state_n = SYNC;
      end
   end

   // Inter-byte gap counter: cleared on every sampled byte and whenever it is idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tcnt <= '0;
      end else if (!tmr_run || rd_pending || timeout) begin
         tcnt <= '0;
      end else begin
         tcnt <= tcnt + TW'(1);
      end
   end

   // Frame bookkeeping: checksum accumulator, length, write index and output index.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc   <= 8'h00;
         len_q <= '0;
         idx   <= '0;
         oidx  <= '0;
      end else begin
         if (rd_pending) begin
            case (state)
               SYNC: begin
                  if (fifo_rd_data_i == SYNC_BYTE) begin
                     acc <= 8'h00;
                     idx <= '0;
                  end
               end
               LEN: begin
                  acc   <= fifo_rd_data_i;
                  len_q <= fifo_rd_data_i[IW-1:0];
                  idx   <= '0;
               end
               PAYLOAD: begin
                  acc <= acc ^ fifo_rd_data_i;
                  idx <= idx_inc;
               end
               default: ;
            endcase
         end
         if (state != EMIT) begin
            oidx <= '0;
         end else if (ready_i) begin
            oidx <= oidx_inc;
         end
      end
   end

   // Payload storage; contents are only meaningful after a complete PAYLOAD phase.
   always_ff @(posedge clk) begin
      if (rd_pending && (state == PAYLOAD)) begin
         buffer[idx[AW-1:0]] <= fifo_rd_data_i;
      end
   end

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// tb_uart_rx_frame_parser: feeds byte streams through a model FIFO and checks pulses,
// error codes and the emitted payload against expectations queued alongside the stimulus.
module tb_uart_rx_frame_parser;

   localparam int CLK_FREQ   = 2_000_000;
   localparam int TIMEOUT_US = 20;
   localparam int MAX_LEN    = 16;
   localparam int TC         = (CLK_FREQ / 1_000_000) * TIMEOUT_US;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       fifo_empty;
   logic [7:0] fifo_rd_data = 8'h00;
   logic       fifo_rd_en;
   logic [7:0] data;
   logic       valid;
   logic       last;
   logic       ready = 1'b1;
   logic       frame_ok;
   logic       frame_err;
   logic [1:0] err_code;

   logic [7:0] fifo_mem [1024];
   int         wp = 0;
   int         rp = 0;

   int         evt_q[$];
   logic [8:0] data_q[$];
   logic [7:0] frame[$];

   int         tests_run = 0;
   int         tests_failed = 0;
   int         cyc = 0;
   int         last_rd_cyc = 0;
   int         ready_mode = 0;
   int         hs_count = 0;
   int         hold_cnt = 0;
   logic       prev_stall = 1'b0;
   logic       prev_last_hs = 1'b0;
   logic [8:0] prev_out = 9'h000;

   uart_rx_frame_parser #(
      .CLK_FREQ  (CLK_FREQ),
      .SYNC_BYTE (8'hA5),
      .MAX_LEN   (MAX_LEN),
      .TIMEOUT_US(TIMEOUT_US)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .fifo_empty_i  (fifo_empty),
      .fifo_rd_data_i(fifo_rd_data),
      .fifo_rd_en_o  (fifo_rd_en),
      .data_o        (data),
      .valid_o       (valid),
      .last_o        (last),
      .ready_i       (ready),
      .frame_ok_o    (frame_ok),
      .frame_err_o   (frame_err),
      .err_code_o    (err_code)
   );

   always #5 clk = ~clk;

   assign fifo_empty = (wp == rp);

   // Model rx FIFO: a strobe pops one byte which appears on the read data the next cycle.
   always @(posedge clk) begin
      if (fifo_rd_en && (wp != rp)) begin
         fifo_rd_data <= fifo_mem[rp % 1024];
         rp <= rp + 1;
      end
   end

   // Hard stop in case something hangs beyond every bounded wait.
   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests_run++;
      if (observed !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [14:0] all_outs();
      return {fifo_rd_en, valid, last, frame_ok, frame_err, err_code, data};
   endfunction

   task automatic applyStimulus(input logic [7:0] bytes[$]);
      foreach (bytes[i]) begin
         fifo_mem[wp % 1024] = bytes[i];
         wp = wp + 1;
      end
   endtask

   task automatic expect_ok();
      evt_q.push_back(0);
   endtask

   task automatic expect_err(input int code);
      evt_q.push_back(code);
   endtask

   task automatic expect_data(input logic [7:0] b, input logic is_last);
      data_q.push_back({is_last, b});
   endtask

   task automatic monitor();
      int         exp_e;
      logic [8:0] exp_d;
      cyc++;
      if (frame_ok || frame_err) begin
         checkOutput("pulse_exclusive", 32'(frame_ok & frame_err), 32'd0);
         if (evt_q.size() > 0) exp_e = evt_q.pop_front();
         else exp_e = -1;
         if (frame_ok) checkOutput("frame_ok_event", 32'(frame_err), 32'(exp_e));
         else checkOutput("frame_err_code", 32'(err_code), 32'(exp_e));
         if (frame_err && (err_code == 2'd3)) checkOutput("timeout_gap", 32'(cyc - last_rd_cyc), 32'(TC + 2));
         else checkOutput("pulse_latency", 32'(cyc - last_rd_cyc), 32'd2);
      end
      if (prev_last_hs) checkOutput("valid_after_last", 32'(valid), 32'd0);
      if (prev_stall) checkOutput("stall_hold", 32'({valid, last, data}), 32'({1'b1, prev_out}));
      if (valid) checkOutput("no_read_in_emit", 32'(fifo_rd_en), 32'd0);
      prev_stall   = valid && !ready;
      prev_out     = {last, data};
      prev_last_hs = valid && ready && last;
      if (valid && ready) begin
         if (data_q.size() > 0) exp_d = data_q.pop_front();
         else exp_d = 9'h1FF;
         checkOutput("payload", 32'({last, data}), 32'(exp_d));
         hs_count++;
      end
      if (fifo_rd_en) last_rd_cyc = cyc;
   endtask

   task automatic tick();
      @(negedge clk);
      case (ready_mode)
         0: ready = 1'b1;
         1: ready = 1'b0;
         default: begin
            if ((hs_count == 2) && (hold_cnt < 20)) begin
               ready = 1'b0;
               hold_cnt++;
            end else begin
               ready = !ready;
            end
         end
      endcase
      monitor();
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (((evt_q.size() > 0) || (data_q.size() > 0) || (wp != rp)) && (n < budget)) begin
         tick();
         n++;
      end
      checkOutput("events_left", 32'(evt_q.size()), 32'd0);
      checkOutput("payload_left", 32'(data_q.size()), 32'd0);
      repeat (6) tick();
   endtask

   task automatic async_reset();
      #2 rst = 1'b1;
      #1 checkOutput("async_reset_outs", 32'(all_outs()), 32'd0);
      evt_q.delete();
      data_q.delete();
      prev_stall   = 1'b0;
      prev_last_hs = 1'b0;
      tick();
      checkOutput("reset_held_outs", 32'(all_outs()), 32'd0);
      rst = 1'b0;
   endtask

   initial begin
      int n;
      ready_mode = 0;
      repeat (3) tick();
      checkOutput("reset_outs", 32'(all_outs()), 32'd0);
      rst = 1'b0;
      tick();

      $display("[TB] happy path");
      frame = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
      applyStimulus(frame);
      expect_ok();
      expect_data(8'h11, 1'b0);
      expect_data(8'h22, 1'b0);
      expect_data(8'h33, 1'b1);
      wait_idle(200);

      $display("[TB] garbage, bad checksum, zero length");
      frame = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h7E, 8'h00};
      applyStimulus(frame);
      expect_err(2);
      wait_idle(200);
      frame = '{8'hA5, 8'h00, 8'h00};
      applyStimulus(frame);
      expect_ok();
      wait_idle(200);

      $display("[TB] length error then sync byte inside payload");
      frame = '{8'hA5, 8'h11};
      applyStimulus(frame);
      expect_err(1);
      wait_idle(200);
      frame = '{8'hA5, 8'h02, 8'hC3, 8'hA5, 8'h64};
      applyStimulus(frame);
      expect_ok();
      expect_data(8'hC3, 1'b0);
      expect_data(8'hA5, 1'b1);
      wait_idle(200);

      $display("[TB] timeout");
      frame = '{8'hA5, 8'h02, 8'hAA};
      applyStimulus(frame);
      expect_err(3);
      wait_idle(200);
      checkOutput("err_code_held", 32'(err_code), 32'd3);
      frame = '{8'hA5, 8'h01, 8'h5A, 8'h5B};
      applyStimulus(frame);
      expect_ok();
      expect_data(8'h5A, 1'b1);
      wait_idle(200);

      $display("[TB] backpressure");
      ready_mode = 2;
      hs_count   = 0;
      hold_cnt   = 0;
      frame = '{8'hA5, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h26};
      applyStimulus(frame);
      expect_ok();
      expect_data(8'hDE, 1'b0);
      expect_data(8'hAD, 1'b0);
      expect_data(8'hBE, 1'b0);
      expect_data(8'hEF, 1'b1);
      wait_idle(300);
      checkOutput("stall_cycles_used", 32'(hold_cnt), 32'd20);
      ready_mode = 0;

      $display("[TB] reset mid-payload");
      frame = '{8'hA5, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40, 8'h44};
      applyStimulus(frame);
      repeat (9) tick();
      async_reset();
      wait_idle(200);

      $display("[TB] reset mid-emit");
      ready_mode = 1;
      frame = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h01};
      applyStimulus(frame);
      expect_ok();
      n = 0;
      while (!valid && (n < 100)) begin
         tick();
         n++;
      end
      checkOutput("emit_reached", 32'(valid), 32'd1);
      checkOutput("emit_head", 32'({last, data}), 32'({1'b0, 8'h01}));
      checkOutput("ok_before_reset", 32'(evt_q.size()), 32'd0);
      repeat (3) tick();
      async_reset();
      ready_mode = 0;
      tick();
      frame = '{8'hA5, 8'h01, 8'h77, 8'h76};
      applyStimulus(frame);
      expect_ok();
      expect_data(8'h77, 1'b1);
      wait_idle(200);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
